servo_motion_seq: RTL and testbench

Debounced trigger-driven motion sequencer that drives the 2-bit position select of the servo PWM stage (`servo_n_pos`). It debounces a raw push-button, selects one of four fixed four-step motion patterns, and steps through it with a fixed dwell per step. It returns the servo to rest when the pattern finishes. Its `pos` output connects directly to the servo stage's `switches[1:0]` input; both blocks run on the same 50 MHz clock.

---
 rtl/servo_motion_seq.sv | 122 ++++++++++++
 tb/tb_servo_motion_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/servo_motion_seq.sv
// Debounced push-button motion sequencer: plays one of four fixed four-step
// position patterns on pos, holding each step for DWELL_CYCLES clocks.
module servo_motion_seq #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DWELL_CYCLES    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [1:0] mode,
    input  logic       stop,
    output logic [1:0] pos,
    output logic       busy,
    output logic       done
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    logic            sync1;
    logic            btn_s;
    logic            btn_db;
    logic            btn_db_d;
    logic            trig;
    logic [DB_W-1:0] db_cnt;

    state_t          state;
    logic [1:0]      mode_q;
    logic [1:0]      step;
    logic [DW_W-1:0] dwell;

    function automatic logic [1:0] pattern(input logic [1:0] m, input logic [1:0] s);
        case (m)
            2'd0:    pattern = s[0] ? 2'd2 : 2'd0;
            2'd1:    pattern = s;
            2'd2:    pattern = s[0] ? 2'd2 : 2'd1;
            default: pattern = 2'd3;
        endcase
    endfunction

    // trig is registered so it lands one cycle after the debounced rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            btn_s    <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_d <= 1'b0;
            trig     <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1    <= btn;
            btn_s    <= sync1;
            btn_db_d <= btn_db;
            trig     <= btn_db & ~btn_db_d;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= 2'd0;
            step   <= 2'd0;
            dwell  <= '0;
            pos    <= 2'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
                step  <= 2'd0;
                dwell <= '0;
                pos   <= 2'd0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (trig) begin
                            mode_q <= mode;
                            step   <= 2'd0;
                            dwell  <= '0;
                            pos    <= pattern(mode, 2'd0);
                            busy   <= 1'b1;
                            state  <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (dwell == DW_LAST) begin
                            dwell <= '0;
                            if (step == 2'd3) begin
                                step  <= 2'd0;
                                pos   <= 2'd0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                step <= step + 2'd1;
                                pos  <= pattern(mode_q, step + 2'd1);
                            end
                        end else begin
                            dwell <= dwell + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servo_motion_seq.sv
// Bench for servo_motion_seq: directed scenarios plus random button/mode/stop
// traffic, checked every cycle against an elapsed-time reference model.
module tb_servo_motion_seq;

    localparam int DEB   = 4;
    localparam int DWELL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       stop = 1'b0;
    logic [1:0] pos;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    servo_motion_seq #(.DEBOUNCE_CYCLES(DEB), .DWELL_CYCLES(DWELL)) dut (
        .clk(clk), .rst(rst), .btn(btn), .mode(mode), .stop(stop),
        .pos(pos), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    // Reference model: sequence position comes from elapsed time since start.
    logic [1:0] pat_tab [4][4] = '{'{2'd0, 2'd2, 2'd0, 2'd2},
                                   '{2'd0, 2'd1, 2'd2, 2'd3},
                                   '{2'd1, 2'd2, 2'd1, 2'd2},
                                   '{2'd3, 2'd3, 2'd3, 2'd3}};
    logic       m_sync[$];
    logic       m_db, m_rise, m_trig, m_play;
    int         m_run, m_el;
    logic [1:0] m_mode, m_pos;
    logic       m_busy, m_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync = '{1'b0, 1'b0};
        m_db = 0; m_rise = 0; m_trig = 0; m_play = 0;
        m_run = 0; m_el = 0; m_mode = 0;
        m_pos = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic model_step();
        logic bs;
        m_done = 0;
        if (stop) begin
            m_play = 0; m_pos = 0; m_busy = 0;
        end else if (m_play) begin
            m_el++;
            if (m_el == 4 * DWELL) begin
                m_play = 0; m_pos = 0; m_busy = 0; m_done = 1;
            end else begin
                m_pos = pat_tab[m_mode][m_el / DWELL];
            end
        end else if (m_trig) begin
            m_play = 1; m_el = 0; m_mode = mode;
            m_pos = pat_tab[mode][0]; m_busy = 1;
        end
        m_trig = m_rise;
        bs = m_sync[0];
        void'(m_sync.pop_front());
        m_sync.push_back(btn);
        m_rise = 0;
        if (bs != m_db) begin
            m_run++;
            if (m_run == DEB) begin
                m_db = bs; m_run = 0; m_rise = bs;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check("pos", 32'(pos), 32'(m_pos));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int rise_at, busy_len, done_cnt, seg, lvl;
        model_reset();

        // reset then quiet idle
        idle(3);
        rst = 1'b0;
        idle(100);

        // short bounces never reach the debounce threshold
        for (int i = 0; i < 20; i++) begin
            btn = ((i / 2) % 2 == 0);
            tick();
        end
        btn = 1'b0;
        busy_len = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busy_len++;
        end
        check("bounce_busy", 32'(busy_len), 32'd0);

        // sweep: start latency, busy length, single done
        mode = 2'd1;
        rise_at = -1; busy_len = 0; done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            btn = (i < 10);
            tick();
            if (busy && rise_at < 0) rise_at = i + 1;
            if (busy) busy_len++;
            if (done) done_cnt++;
        end
        check("start_latency", 32'(rise_at), 32'd8);
        check("busy_len", 32'(busy_len), 32'(4 * DWELL));
        check("done_pulses", 32'(done_cnt), 32'd1);

        // wiggle with a second press and a mode change mid-play
        mode = 2'd2;
        busy_len = 0;
        for (int i = 0; i < 70; i++) begin
            btn = (i < 10) || (i >= 20 && i < 30);
            if (i == 20) mode = 2'd0;
            tick();
            if (busy) busy_len++;
        end
        check("no_restart_len", 32'(busy_len), 32'(4 * DWELL));
        idle(10);

        // nod aborted by a one-cycle stop during step 2
        mode = 2'd0;
        done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            btn = (i < 10);
            stop = (i == 8 + 2 * DWELL + 2);
            tick();
            if (done) done_cnt++;
        end
        stop = 1'b0;
        check("abort_done", 32'(done_cnt), 32'd0);

        // hold pattern hit by async reset mid-step 1
        mode = 2'd3;
        for (int i = 0; i < 8 + DWELL + 3; i++) begin
            btn = (i < 10);
            tick();
        end
        check("pre_rst_busy", 32'(busy), 32'd1);
        #4 rst = 1'b1;
        #1;
        check("async_rst_pos", 32'(pos), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        model_reset();
        btn = 1'b0;
        idle(2);
        rst = 1'b0;
        busy_len = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (busy) busy_len++;
        end
        check("post_rst_idle", 32'(busy_len), 32'd0);

        // random traffic
        for (int k = 0; k < 150; k++) begin
            seg = $urandom_range(1, 14);
            lvl = $urandom_range(0, 1);
            for (int i = 0; i < seg; i++) begin
                btn  = lvl[0];
                mode = 2'($urandom_range(0, 3));
                stop = ($urandom_range(0, 60) == 0);
                tick();
            end
        end
        stop = 1'b0;
        btn  = 1'b0;
        idle(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
